// File: rtl/calc_bcd_sequencer_if.sv
`default_nettype none
//==============================================================================
// Interface : calc_bcd_sequencer_if
// Purpose   : Bundles the keypad event bus, the BCD arithmetic-unit bus and
//             the display/status outputs of the calculator sequencer.
// Signals   : key_valid/key_code          keypad event (one-cycle pulse)
//             numero_1/numero_2/suma_resta operands and operator to the unit
//             igual_en                     one-cycle operation strobe
//             resultado/operacion_valida   result and valid flag from the unit
//             display/busy/error           display digits and status
// Modports  : master - the sequencer; slave - keypad, arithmetic unit, display
// Revision  : 1.0 - initial release
//==============================================================================
interface calc_bcd_sequencer_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] numero_1;
   logic [15:0] numero_2;
   logic [1:0]  suma_resta;
   logic        igual_en;
   logic [15:0] resultado;
   logic        operacion_valida;
   logic [15:0] display;
   logic        busy;
   logic        error;

   modport master (
      input  key_valid, key_code, resultado, operacion_valida,
      output numero_1, numero_2, suma_resta, igual_en, display, busy, error
   );

   modport slave (
      output key_valid, key_code, resultado, operacion_valida,
      input  numero_1, numero_2, suma_resta, igual_en, display, busy, error
   );
endinterface
`default_nettype wire

// File: rtl/calc_bcd_sequencer.sv
`default_nettype none
//==============================================================================
// Module    : calc_bcd_sequencer
// Purpose   : Keypad-driven sequencer for a 4-digit BCD add/subtract unit.
//             Builds operand A, the operator and operand B from key events,
//             fires a one-cycle strobe on '=', samples the unit's result and
//             valid flag after RESULT_LAT cycles and drives the display.
// Ports     : clk    - system clock
//             reset  - asynchronous, active-high reset
//             bus    - calc_bcd_sequencer_if.master (keys, unit bus, display,
//                      busy, error); all outputs are registered
// Params    : MAX_DIGITS - digits accepted per operand (1..4)
//             RESULT_LAT - cycles after the strobe cycle until the result is
//                          sampled (>=1)
// Revision  : 1.0 - initial release
//==============================================================================
module calc_bcd_sequencer #(
   parameter int MAX_DIGITS = 4,
   parameter int RESULT_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   calc_bcd_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam int LAT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   localparam logic [CNT_W-1:0] c_max_cnt   = CNT_W'(MAX_DIGITS);
   localparam logic [LAT_W-1:0] c_wait_init = LAT_W'(RESULT_LAT - 1);
   localparam logic [3:0]       c_key_add   = 4'hA;
   localparam logic [3:0]       c_key_sub   = 4'hB;
   localparam logic [3:0]       c_key_eq    = 4'hC;
   localparam logic [3:0]       c_key_clr   = 4'hD;
   localparam logic [1:0]       c_op_add    = 2'd1;
   localparam logic [1:0]       c_op_sub    = 2'd2;
   localparam logic [15:0]      c_disp_err  = 16'hEEEE;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SHOW    = 3'd4,
      ST_ERROR   = 3'd5
   } state_t;

   state_t           r_state;
   logic [15:0]      r_num_a;
   logic [15:0]      r_num_b;
   logic [1:0]       r_op;
   logic             r_strobe;
   logic             r_busy;
   logic             r_error;
   logic [15:0]      r_display;
   logic [15:0]      r_result;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;
   logic [LAT_W-1:0] r_wait_cnt;

   logic        w_key_digit;
   logic        w_key_op;
   logic        w_key_eq;
   logic        w_key_clr;
   logic [1:0]  w_op_sel;
   logic [15:0] w_a_shift;
   logic [15:0] w_b_shift;
   logic [15:0] w_digit_ext;

   // Key decode; codes E/F fall into none of these classes and are ignored.
   assign w_key_digit = bus.key_valid && (bus.key_code <= 4'd9);
   assign w_key_op    = bus.key_valid && ((bus.key_code == c_key_add) ||
                                          (bus.key_code == c_key_sub));
   assign w_key_eq    = bus.key_valid && (bus.key_code == c_key_eq);
   assign w_key_clr   = bus.key_valid && (bus.key_code == c_key_clr);
   assign w_op_sel    = (bus.key_code == c_key_sub) ? c_op_sub : c_op_add;
   assign w_a_shift   = {r_num_a[11:0], bus.key_code};
   assign w_b_shift   = {r_num_b[11:0], bus.key_code};
   assign w_digit_ext = {12'h000, bus.key_code};

   // Display is updated at every transition that changes what it should show,
   // so it stays a plain register with no path from the key inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_ENTER_A;
         r_num_a    <= 16'h0000;
         r_num_b    <= 16'h0000;
         r_op       <= 2'd0;
         r_strobe   <= 1'b0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
         r_display  <= 16'h0000;
         r_result   <= 16'h0000;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_strobe <= 1'b0;
         if (w_key_clr) begin
            // Clear wins in every state, including a pending operation.
            r_state    <= ST_ENTER_A;
            r_num_a    <= 16'h0000;
            r_num_b    <= 16'h0000;
            r_op       <= 2'd0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_display  <= 16'h0000;
            r_result   <= 16'h0000;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_wait_cnt <= '0;
         end else begin
            case (r_state)
               ST_ENTER_A: begin
                  if (w_key_digit && (r_cnt_a < c_max_cnt)) begin
                     r_num_a   <= w_a_shift;
                     r_cnt_a   <= r_cnt_a + CNT_W'(1);
                     r_display <= w_a_shift;
                  end else if (w_key_op) begin
                     r_op      <= w_op_sel;
                     r_num_b   <= 16'h0000;
                     r_cnt_b   <= '0;
                     r_display <= r_num_a;
                     r_state   <= ST_ENTER_B;
                  end
               end

               ST_ENTER_B: begin
                  if (w_key_digit && (r_cnt_b < c_max_cnt)) begin
                     r_num_b   <= w_b_shift;
                     r_cnt_b   <= r_cnt_b + CNT_W'(1);
                     r_display <= w_b_shift;
                  end else if (w_key_op && (r_cnt_b == '0)) begin
                     r_op <= w_op_sel;
                  end else if (w_key_eq) begin
                     r_strobe <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= ST_EXEC;
                  end
               end

               ST_EXEC: begin
                  // The strobe cycle counts as cycle 0; the result is sampled
                  // at the end of cycle RESULT_LAT.
                  r_wait_cnt <= c_wait_init;
                  r_state    <= ST_WAIT;
               end

               ST_WAIT: begin
                  if (r_wait_cnt == '0) begin
                     r_busy <= 1'b0;
                     if (bus.operacion_valida) begin
                        r_result  <= bus.resultado;
                        r_display <= bus.resultado;
                        r_state   <= ST_SHOW;
                     end else begin
                        r_error   <= 1'b1;
                        r_display <= c_disp_err;
                        r_state   <= ST_ERROR;
                     end
                  end else begin
                     r_wait_cnt <= r_wait_cnt - LAT_W'(1);
                  end
               end

               ST_SHOW: begin
                  if (w_key_digit) begin
                     r_num_a   <= w_digit_ext;
                     r_cnt_a   <= CNT_W'(1);
                     r_display <= w_digit_ext;
                     r_state   <= ST_ENTER_A;
                  end else if (w_key_op) begin
                     // Chain: the result becomes a full operand A.
                     r_num_a   <= r_result;
                     r_cnt_a   <= c_max_cnt;
                     r_op      <= w_op_sel;
                     r_num_b   <= 16'h0000;
                     r_cnt_b   <= '0;
                     r_display <= r_result;
                     r_state   <= ST_ENTER_B;
                  end else if (w_key_eq) begin
                     // Repeat the last operation on the result, B unchanged.
                     r_num_a  <= r_result;
                     r_cnt_a  <= c_max_cnt;
                     r_strobe <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= ST_EXEC;
                  end
               end

               ST_ERROR: begin
                  if (w_key_digit) begin
                     r_error   <= 1'b0;
                     r_num_a   <= w_digit_ext;
                     r_cnt_a   <= CNT_W'(1);
                     r_display <= w_digit_ext;
                     r_state   <= ST_ENTER_A;
                  end
               end

               default: begin
                  r_state <= ST_ENTER_A;
               end
            endcase
         end
      end
   end

   assign bus.numero_1   = r_num_a;
   assign bus.numero_2   = r_num_b;
   assign bus.suma_resta = r_op;
   assign bus.igual_en   = r_strobe;
   assign bus.display    = r_display;
   assign bus.busy       = r_busy;
   assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_calc_bcd_sequencer.sv
`default_nettype none
//==============================================================================
// Module    : tb_calc_bcd_sequencer
// Purpose   : Self-checking bench for calc_bcd_sequencer. A RESULT_LAT=1
//             instance runs directed vectors, hand-written corner sequences
//             and random keys against a decimal-arithmetic reference model;
//             a RESULT_LAT=3 instance checks the longer sampling latency.
//             Each instance talks to a small arithmetic-unit model whose
//             valid flag is high only in the cycle the result must be taken.
// Revision  : 1.0 - initial release
//==============================================================================
module tb_calc_bcd_sequencer;

   localparam int         LAT       = 1;
   localparam int         LAT3      = 3;
   localparam int         SETTLE_EQ = 6;
   localparam logic [3:0] K_ADD     = 4'hA;
   localparam logic [3:0] K_SUB     = 4'hB;
   localparam logic [3:0] K_EQ      = 4'hC;
   localparam logic [3:0] K_CLR     = 4'hD;
   localparam logic [3:0] K_NOP     = 4'hE;
   localparam int         M_A       = 0;
   localparam int         M_B       = 1;
   localparam int         M_SHOW    = 2;
   localparam int         M_ERR     = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks       = 0;
   int   failures     = 0;
   int   pulses       = 0;
   int   pulses3      = 0;
   int   busy3_cycles = 0;
   bit   alu_fail     = 1'b0;

   calc_bcd_sequencer_if bus ();
   calc_bcd_sequencer_if bus3 ();

   calc_bcd_sequencer #(.MAX_DIGITS(4), .RESULT_LAT(LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   calc_bcd_sequencer #(.MAX_DIGITS(4), .RESULT_LAT(LAT3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.master)
   );

   always #5 clk = ~clk;

   assign bus3.key_valid = bus.key_valid;
   assign bus3.key_code  = bus.key_code;

   // ---------------- helpers ----------------
   function automatic int bcd2int(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int          x;
      x = (v < 0) ? 0 : v % 10000;
      r[3:0]   = 4'(x % 10);
      r[7:4]   = 4'((x / 10) % 10);
      r[11:8]  = 4'((x / 100) % 10);
      r[15:12] = 4'((x / 1000) % 10);
      return r;
   endfunction

   function automatic int alu_calc(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] op);
      return (op == 2'd2) ? bcd2int(a) - bcd2int(b) : bcd2int(a) + bcd2int(b);
   endfunction

   // ---------------- arithmetic unit models ----------------
   int          alu_cnt  = 0;
   logic [15:0] alu_val  = 16'h0;
   bit          alu_ok   = 1'b0;
   int          alu3_cnt = 0;
   logic [15:0] alu3_val = 16'h0;
   bit          alu3_ok  = 1'b0;

   always @(posedge clk) begin
      if (bus.igual_en) begin
         alu_cnt <= LAT;
         alu_val <= int2bcd(alu_calc(bus.numero_1, bus.numero_2, bus.suma_resta));
         alu_ok  <= !alu_fail && (alu_calc(bus.numero_1, bus.numero_2, bus.suma_resta) >= 0)
                    && (alu_calc(bus.numero_1, bus.numero_2, bus.suma_resta) <= 9999);
      end else if (alu_cnt > 0) begin
         alu_cnt <= alu_cnt - 1;
      end
      if (bus3.igual_en) begin
         alu3_cnt <= LAT3;
         alu3_val <= int2bcd(alu_calc(bus3.numero_1, bus3.numero_2, bus3.suma_resta));
         alu3_ok  <= !alu_fail && (alu_calc(bus3.numero_1, bus3.numero_2, bus3.suma_resta) >= 0)
                     && (alu_calc(bus3.numero_1, bus3.numero_2, bus3.suma_resta) <= 9999);
      end else if (alu3_cnt > 0) begin
         alu3_cnt <= alu3_cnt - 1;
      end
   end

   // Valid only in the single cycle where the sequencer must sample it.
   assign bus.resultado         = alu_val;
   assign bus.operacion_valida  = alu_ok && (alu_cnt == 1);
   assign bus3.resultado        = alu3_val;
   assign bus3.operacion_valida = alu3_ok && (alu3_cnt == 1);

   always @(posedge clk) begin
      if (bus.igual_en)  pulses       <= pulses + 1;
      if (bus3.igual_en) pulses3      <= pulses3 + 1;
      if (bus3.busy)     busy3_cycles <= busy3_cycles + 1;
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input logic [15:0] n1, input logic [15:0] n2,
                            input logic [1:0] op, input logic [15:0] disp, input logic err);
      check($sformatf("%s.numero_1", tag), bus.numero_1, n1);
      check($sformatf("%s.numero_2", tag), bus.numero_2, n2);
      check($sformatf("%s.suma_resta", tag), 16'(bus.suma_resta), 16'(op));
      check($sformatf("%s.display", tag), bus.display, disp);
      check($sformatf("%s.error", tag), 16'(bus.error), 16'(err));
   endtask

   // Called on a falling edge; the key is seen by exactly one rising edge.
   task automatic press(input logic [3:0] k, input int settle);
      bus.key_valid = 1'b1;
      bus.key_code  = k;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      repeat (settle) @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic [3:0]  key;
      logic        fail;
      logic [15:0] n1;
      logic [15:0] n2;
      logic [1:0]  op;
      logic [15:0] disp;
      logic        err;
      logic [1:0]  pulse;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] k, input logic f, input logic [15:0] n1,
                               input logic [15:0] n2, input logic [1:0] op,
                               input logic [15:0] d, input logic e, input logic [1:0] p);
      vec_t v;
      v.key = k; v.fail = f; v.n1 = n1; v.n2 = n2; v.op = op; v.disp = d; v.err = e; v.pulse = p;
      return v;
   endfunction

   // ---------------- reference model (decimal, per key) ----------------
   int m_mode, m_a, m_b, m_op, m_ca, m_cb, m_res, m_pulses;

   function automatic logic [15:0] m_disp();
      case (m_mode)
         M_A:     return int2bcd(m_a);
         M_B:     return (m_cb > 0) ? int2bcd(m_b) : int2bcd(m_a);
         M_SHOW:  return int2bcd(m_res);
         default: return 16'hEEEE;
      endcase
   endfunction

   task automatic model_exec(input bit fail);
      int s;
      m_pulses++;
      s = (m_op == 2) ? m_a - m_b : m_a + m_b;
      if (!fail && s >= 0 && s <= 9999) begin
         m_res  = s;
         m_mode = M_SHOW;
      end else begin
         m_mode = M_ERR;
      end
   endtask

   task automatic model_key(input logic [3:0] k, input bit fail);
      int d;
      bit is_dig, is_op;
      d      = int'(k);
      is_dig = (k <= 4'd9);
      is_op  = (k == K_ADD) || (k == K_SUB);
      if (k == K_CLR) begin
         m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_ca = 0; m_cb = 0;
      end else begin
         case (m_mode)
            M_A: begin
               if (is_dig && m_ca < 4) begin m_a = m_a * 10 + d; m_ca++; end
               else if (is_op) begin m_op = (k == K_SUB) ? 2 : 1; m_b = 0; m_cb = 0; m_mode = M_B; end
            end
            M_B: begin
               if (is_dig && m_cb < 4) begin m_b = m_b * 10 + d; m_cb++; end
               else if (is_op && m_cb == 0) m_op = (k == K_SUB) ? 2 : 1;
               else if (k == K_EQ) model_exec(fail);
            end
            M_SHOW: begin
               if (is_dig) begin m_a = d; m_ca = 1; m_mode = M_A; end
               else if (is_op) begin
                  m_a = m_res; m_ca = 4; m_op = (k == K_SUB) ? 2 : 1;
                  m_b = 0; m_cb = 0; m_mode = M_B;
               end else if (k == K_EQ) begin
                  m_a = m_res; m_ca = 4; model_exec(fail);
               end
            end
            default: begin
               if (is_dig) begin m_a = d; m_ca = 1; m_mode = M_A; end
            end
         endcase
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int p0, p3, b3;

      // key, fail, numero_1, numero_2, op, display, error, pulses
      vecs.push_back(mk(4'h1,  0, 16'h0001, 16'h0000, 2'd0, 16'h0001, 0, 0));
      vecs.push_back(mk(4'h2,  0, 16'h0012, 16'h0000, 2'd0, 16'h0012, 0, 0));
      vecs.push_back(mk(K_ADD, 0, 16'h0012, 16'h0000, 2'd1, 16'h0012, 0, 0));
      vecs.push_back(mk(4'h3,  0, 16'h0012, 16'h0003, 2'd1, 16'h0003, 0, 0));
      vecs.push_back(mk(K_NOP, 0, 16'h0012, 16'h0003, 2'd1, 16'h0003, 0, 0));
      vecs.push_back(mk(4'h4,  0, 16'h0012, 16'h0034, 2'd1, 16'h0034, 0, 0));
      vecs.push_back(mk(K_EQ,  0, 16'h0012, 16'h0034, 2'd1, 16'h0046, 0, 1));
      vecs.push_back(mk(K_CLR, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0, 0));
      vecs.push_back(mk(4'h9,  0, 16'h0009, 16'h0000, 2'd0, 16'h0009, 0, 0));
      vecs.push_back(mk(4'h9,  0, 16'h0099, 16'h0000, 2'd0, 16'h0099, 0, 0));
      vecs.push_back(mk(4'h9,  0, 16'h0999, 16'h0000, 2'd0, 16'h0999, 0, 0));
      vecs.push_back(mk(4'h9,  0, 16'h9999, 16'h0000, 2'd0, 16'h9999, 0, 0));
      vecs.push_back(mk(4'h9,  0, 16'h9999, 16'h0000, 2'd0, 16'h9999, 0, 0));
      vecs.push_back(mk(K_ADD, 0, 16'h9999, 16'h0000, 2'd1, 16'h9999, 0, 0));
      vecs.push_back(mk(4'h1,  0, 16'h9999, 16'h0001, 2'd1, 16'h0001, 0, 0));
      vecs.push_back(mk(K_EQ,  1, 16'h9999, 16'h0001, 2'd1, 16'hEEEE, 1, 1));
      vecs.push_back(mk(K_EQ,  0, 16'h9999, 16'h0001, 2'd1, 16'hEEEE, 1, 0));
      vecs.push_back(mk(4'h7,  0, 16'h0007, 16'h0001, 2'd1, 16'h0007, 0, 0));
      vecs.push_back(mk(K_EQ,  0, 16'h0007, 16'h0001, 2'd1, 16'h0007, 0, 0));
      vecs.push_back(mk(K_CLR, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0, 0));
      vecs.push_back(mk(4'h5,  0, 16'h0005, 16'h0000, 2'd0, 16'h0005, 0, 0));
      vecs.push_back(mk(K_ADD, 0, 16'h0005, 16'h0000, 2'd1, 16'h0005, 0, 0));
      vecs.push_back(mk(K_SUB, 0, 16'h0005, 16'h0000, 2'd2, 16'h0005, 0, 0));
      vecs.push_back(mk(4'h2,  0, 16'h0005, 16'h0002, 2'd2, 16'h0002, 0, 0));
      vecs.push_back(mk(K_ADD, 0, 16'h0005, 16'h0002, 2'd2, 16'h0002, 0, 0));
      vecs.push_back(mk(K_EQ,  0, 16'h0005, 16'h0002, 2'd2, 16'h0003, 0, 1));
      vecs.push_back(mk(K_EQ,  0, 16'h0003, 16'h0002, 2'd2, 16'h0001, 0, 1));
      vecs.push_back(mk(K_ADD, 0, 16'h0001, 16'h0000, 2'd1, 16'h0001, 0, 0));
      vecs.push_back(mk(K_EQ,  0, 16'h0001, 16'h0000, 2'd1, 16'h0001, 0, 1));
      vecs.push_back(mk(4'h4,  0, 16'h0004, 16'h0000, 2'd1, 16'h0004, 0, 0));
      vecs.push_back(mk(K_CLR, 0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0, 0));

      reset         = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check_dut("reset", 16'h0, 16'h0, 2'd0, 16'h0, 1'b0);
      check("reset.busy", 16'(bus.busy), 16'h0);
      check("reset.igual_en", 16'(bus.igual_en), 16'h0);

      // Directed vectors
      for (int i = 0; i < vecs.size(); i++) begin
         alu_fail = vecs[i].fail;
         p0 = pulses;
         press(vecs[i].key, (vecs[i].key == K_EQ) ? SETTLE_EQ : 1);
         check_dut($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, vecs[i].op,
                   vecs[i].disp, vecs[i].err);
         check($sformatf("vec%0d.pulses", i), 16'(pulses - p0), 16'(vecs[i].pulse));
      end
      alu_fail = 1'b0;

      // Clear on the strobe cycle: strobe drops, nothing is shown
      press(4'h1, 1); press(K_ADD, 1); press(4'h2, 1);
      p0 = pulses;
      bus.key_valid = 1'b1; bus.key_code = K_EQ;
      @(negedge clk);
      check("clr_exec.igual_en_high", 16'(bus.igual_en), 16'h1);
      bus.key_code = K_CLR;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.key_code = 4'h0;
      check("clr_exec.igual_en_low", 16'(bus.igual_en), 16'h0);
      check("clr_exec.busy", 16'(bus.busy), 16'h0);
      repeat (5) @(negedge clk);
      check_dut("clr_exec", 16'h0, 16'h0, 2'd0, 16'h0, 1'b0);
      check("clr_exec.pulses", 16'(pulses - p0), 16'h1);

      // Keys during EXEC and WAIT are dropped
      press(4'h1, 1); press(K_ADD, 1); press(4'h2, 1);
      bus.key_valid = 1'b1; bus.key_code = K_EQ;
      @(negedge clk);
      bus.key_code = 4'h7;
      @(negedge clk);
      check("drop.busy_in_wait", 16'(bus.busy), 16'h1);
      bus.key_code = 4'h8;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.key_code = 4'h0;
      check_dut("drop", 16'h0001, 16'h0002, 2'd1, 16'h0003, 1'b0);
      check("drop.busy", 16'(bus.busy), 16'h0);

      // Asynchronous reset while waiting for the result
      press(K_CLR, 1);
      press(4'h1, 1); press(K_ADD, 1); press(4'h2, 1);
      bus.key_valid = 1'b1; bus.key_code = K_EQ;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.key_code = 4'h0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check_dut("async_rst", 16'h0, 16'h0, 2'd0, 16'h0, 1'b0);
      check("async_rst.busy", 16'(bus.busy), 16'h0);
      check("async_rst.igual_en", 16'(bus.igual_en), 16'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      p0 = pulses;
      press(4'h3, 1);
      press(K_EQ, SETTLE_EQ);
      check_dut("after_rst", 16'h0003, 16'h0, 2'd0, 16'h0003, 1'b0);
      check("after_rst.pulses", 16'(pulses - p0), 16'h0);

      // RESULT_LAT = 3 instance: sampling window and busy length
      press(K_CLR, 1);
      press(4'h1, 1); press(K_ADD, 1); press(4'h2, 1);
      p3 = pulses3;
      b3 = busy3_cycles;
      press(K_EQ, SETTLE_EQ);
      check("lat3.display", bus3.display, 16'h0003);
      check("lat3.error", 16'(bus3.error), 16'h0);
      check("lat3.pulses", 16'(pulses3 - p3), 16'h1);
      check("lat3.busy_cycles", 16'(busy3_cycles - b3), 16'h4);
      check("lat3.busy_end", 16'(bus3.busy), 16'h0);

      // Random keys against the reference model
      press(K_CLR, 1);
      m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_ca = 0; m_cb = 0; m_res = 0;
      m_pulses = pulses;
      for (int n = 0; n < 400; n++) begin
         logic [3:0] k;
         int         r;
         bit         f;
         r = $urandom_range(0, 99);
         if (r < 55)      k = 4'($urandom_range(0, 9));
         else if (r < 66) k = K_ADD;
         else if (r < 76) k = K_SUB;
         else if (r < 90) k = K_EQ;
         else if (r < 94) k = K_CLR;
         else             k = 4'($urandom_range(14, 15));
         f = ($urandom_range(0, 4) == 0);
         alu_fail = f;
         model_key(k, f);
         press(k, (k == K_EQ) ? SETTLE_EQ : int'($urandom_range(0, 1)));
         check_dut($sformatf("rnd%0d", n), int2bcd(m_a), int2bcd(m_b), 2'(m_op),
                   m_disp(), (m_mode == M_ERR));
         check($sformatf("rnd%0d.pulses", n), 16'(pulses), 16'(m_pulses));
         check($sformatf("rnd%0d.busy", n), 16'(bus.busy), 16'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
